// File: rtl/mem_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encodings and the
// requester port identifiers used by the arbiter and its round-robin unit.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Port IDs double as bit positions in the req/grant vectors.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VGA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic (purely combinational).
//   req[1:0]   : request vector, bit PORT_CPU / bit PORT_VGA
//   last       : port granted most recently (pointer held by the caller)
//   grant[1:0] : one-hot grant, all zero when nothing is requested
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      // Tie: the port that did not win last time goes now.
      if (last == PORT_VGA) grant = 2'b01;
      else                  grant = 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU port (read/write) and a VGA port (read-only) onto a
// 16-bit RAM controller, splitting every 32-bit access into a low and a
// high half-word transfer. All outputs are registered.
//   cpu_req/addr/we/wdata : CPU request, held until cpu_done
//   vga_req/addr          : VGA read request, held until vga_done
//   cpu_done, vga_done    : one-cycle completion pulse
//   rdata, err            : read word and timeout flag, valid with done
//   busy                  : high whenever the FSM is not idle
//   mem_req/addr/we/wdata : half-word request to the RAM controller
//   mem_ack, mem_rdata    : half-word acknowledge and read data
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_wdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              cpu_done,
  output logic              vga_done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

  // Last no-ack cycle allowed before the access is aborted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              last_q, last_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        wait_q, wait_d;
  logic              cpu_done_q, cpu_done_d;
  logic              vga_done_q, vga_done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;

  logic [1:0]        grant;
  logic              new_vga;
  logic [ADDR_W-3:0] new_addr;
  logic              new_we;
  logic [31:0]       new_wdata;
  logic              finish;
  logic              timed_out;

  // Byte-lane bits of the word addresses carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], vga_addr[1:0]};

  rr_arb2 u_rr_arb2 (
    .req   ({vga_req, cpu_req}),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    last_d      = last_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    cpu_done_d  = 1'b0;
    vga_done_d  = 1'b0;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    finish      = 1'b0;
    timed_out   = 1'b0;

    new_vga   = grant[PORT_VGA];
    new_addr  = new_vga ? vga_addr[ADDR_W-1:2] : cpu_addr[ADDR_W-1:2];
    new_we    = ~new_vga & cpu_we;
    new_wdata = new_vga ? 32'h0 : cpu_wdata;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req | vga_req) begin
          state_d     = ST_LO;
          port_d      = new_vga;
          addr_d      = new_addr;
          we_d        = new_we;
          wdata_d     = new_wdata;
          wait_d      = 8'd0;
          // Outputs are registered, so the LO-phase request is loaded here.
          mem_req_d   = 1'b1;
          mem_addr_d  = {new_addr, 1'b0};
          mem_we_d    = new_we;
          mem_wdata_d = new_wdata[15:0];
        end
      end
      ST_LO: begin
        if (mem_ack) begin
          state_d     = ST_HI;
          rdata_d     = {rdata_q[31:16], mem_rdata};
          wait_d      = 8'd0;
          mem_addr_d  = {addr_q, 1'b1};
          mem_wdata_d = wdata_q[31:16];
        end else if (wait_q == WAIT_LAST) begin
          timed_out = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_HI: begin
        if (mem_ack) begin
          rdata_d = {mem_rdata, rdata_q[15:0]};
          finish  = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          timed_out = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = port_q;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish | timed_out) begin
      state_d    = ST_DONE;
      mem_req_d  = 1'b0;
      mem_we_d   = 1'b0;
      cpu_done_d = (port_q == PORT_CPU);
      vga_done_d = (port_q == PORT_VGA);
      err_d      = timed_out;
      if (timed_out) rdata_d = 32'h0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_CPU;
      last_q      <= PORT_VGA;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      wait_q      <= 8'd0;
      cpu_done_q  <= 1'b0;
      vga_done_q  <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      cpu_done_q  <= cpu_done_d;
      vga_done_q  <= vga_done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_done  = cpu_done_q;
  assign vga_done  = vga_done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for mem_ack per half-word before abort (range 1..255).
REQ-002 SHALL have parameter ADDR_W, default 32, giving the requester byte-address width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cpu_req, vga_req  input  1 each  requester holds high until its done.
REQ-006 cpu_addr, vga_addr  input  ADDR_W each  word-aligned byte address; bits [1:0] ignored.
REQ-007 cpu_we  input  1  write when high; VGA port is read-only.
REQ-008 cpu_wdata  input  32  write data.
REQ-009 cpu_done, vga_done  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  32  read data, valid in the done cycle; shared by both ports.
REQ-011 err  output  1  high with done when the access timed out.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 mem_req  output  1  half-word request to the RAM controller.
REQ-014 mem_addr  output  ADDR_W-1  half-word address.
REQ-015 mem_we  output  1  half-word write.
REQ-016 mem_wdata  output  16  half-word write data.
REQ-017 mem_ack  input  1  one-cycle half-word acknowledge.
REQ-018 mem_rdata  input  16  read half-word, valid with mem_ack.

Function
REQ-019 FSM states SHALL be IDLE, LO, HI and DONE; all outputs registered.
REQ-020 IDLE: if any req is sampled, grant and latch addr/we/wdata, then go to LO next cycle; otherwise stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: a single requester wins; on simultaneous requests the port not granted last wins; the last-grant pointer resets to VGA, so CPU wins the first tie.
REQ-022 LO: mem_req=1, mem_addr={addr[ADDR_W-1:2],1'b0}, mem_wdata=wdata[15:0], mem_we=we; on mem_ack, capture mem_rdata into rdata[15:0] and go to HI.
REQ-023 HI: mem_req stays 1 with no gap; mem_addr={addr[ADDR_W-1:2],1'b1}, mem_wdata=wdata[31:16]; on mem_ack, capture rdata[31:16] and go to DONE.
REQ-024 DONE: mem_req=0, pulse the granted port's done for exactly one cycle, update the pointer, return to IDLE.
REQ-025 Minimum latency: req sampled in cycle 0 with immediate acks gives done in cycle 3; each ack wait adds one cycle per wait.
REQ-026 Wait counter: clears on entry to LO or HI, increments each cycle without mem_ack, and on reaching TIMEOUT goes to DONE with err=1, mem_req=0 and rdata=0.
REQ-027 Requester SHALL drop req the cycle after done; because IDLE re-samples, a req still high is a new request (back-to-back allowed).
REQ-028 mem_ack outside LO/HI SHALL be ignored; req changes while not in IDLE SHALL be ignored.
REQ-029 For VGA grants, mem_we SHALL be 0 regardless of cpu_we.
REQ-030 err SHALL be 0 except in a timed-out DONE cycle.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_done=vga_done=0, rdata=0, err=0, busy=0, wait counter=0, pointer=VGA.
REQ-032 Reset during LO/HI SHALL abandon the transfer without any done pulse.
REQ-033 Deassertion SHALL take effect at the first rising clk edge after rst_n goes high.

Structure
REQ-034 State encodings (IDLE=0, LO=1, HI=2, DONE=3) and the port IDs (CPU=0, VGA=1) SHALL live in shared package mem_pkg.
REQ-035 Round-robin grant logic SHALL be the sub-module rr_arb2 (inputs req[1:0] and last; output grant[1:0]), combinational plus the pointer register.

Verification
REQ-036 CPU read 0x0000_0010, acks immediate, mem_rdata 0x1234 then 0xABCD -> mem_addr 0x8 then 0x9; cpu_done in cycle 3; rdata=0xABCD1234.
REQ-037 CPU write 0x20 data 0xDEADBEEF -> mem_we=1, mem_wdata 0xBEEF at 0x10, then 0xDEAD at 0x11; cpu_done; err=0.
REQ-038 cpu_req and vga_req both high from reset, held -> order CPU, VGA, CPU, VGA; each done is a single-cycle pulse.
REQ-039 TIMEOUT=4 with mem_ack never asserted -> done with err=1 and rdata=0 after 4 wait cycles in LO; mem_req=0 in DONE.
REQ-040 rst_n pulsed low mid-HI -> mem_req=0 immediately, no done pulse, state IDLE; a new request then completes normally.
